// File: rtl/load_align_ctrl_if.sv
// load_align_ctrl_if: request, memory-read, writeback and status signals of the load unit.
interface load_align_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_load_sel;
   logic [31:0] req_rt_old;
   logic [4:0]  req_dest;
   logic        flush;
   logic        mem_rd_valid;
   logic        mem_rd_ready;
   logic [31:0] mem_rd_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic [3:0]  wb_ben;
   logic        adel;
   logic        busy;
   modport slave (
      input  req_valid, req_addr, req_load_sel, req_rt_old, req_dest, flush,
             mem_rd_ready, mem_rsp_valid, mem_rsp_data, wb_ready,
      output req_ready, mem_rd_valid, mem_rd_addr, wb_valid, wb_dest, wb_data, wb_ben, adel, busy
   );
   modport master (
      output req_valid, req_addr, req_load_sel, req_rt_old, req_dest, flush,
             mem_rd_ready, mem_rsp_valid, mem_rsp_data, wb_ready,
      input  req_ready, mem_rd_valid, mem_rd_addr, wb_valid, wb_dest, wb_data, wb_ben, adel, busy
   );
endinterface

// File: rtl/load_align_ctrl.sv
// load_align_ctrl: one-at-a-time load sequencer; checks alignment, issues a word read,
// then aligns/extends the returned word and merges it with the old register value.
module load_align_ctrl #(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic             clk,
   input  logic             resetn,
   load_align_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DRAIN} state_t;
   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d, rt_old_q, rt_old_d, wb_data_q, wb_data_d;
   logic [2:0]  sel_q, sel_d;
   logic [4:0]  dest_q, dest_d;
   logic [3:0]  wb_ben_q, wb_ben_d;
   logic        adel_q, adel_d;
   logic [1:0]  k;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] shifted, mask, merged;
   logic [3:0]  ben;
   logic        misaligned;
   always_comb begin
      k = addr_q[1:0] ^ {2{BIG_ENDIAN}};
      byte_v = bus.mem_rsp_data[{k, 3'b000} +: 8];
      half_v = k[1] ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0];
      shifted = bus.mem_rsp_data;
      ben = 4'hf;
      case (sel_q)
         3'd0: shifted = {{24{byte_v[7]}}, byte_v};
         3'd1: shifted = {24'd0, byte_v};
         3'd2: shifted = {{16{half_v[15]}}, half_v};
         3'd3: shifted = {16'd0, half_v};
         3'd5: begin
            shifted = bus.mem_rsp_data << {~k, 3'b000};
            ben = 4'hf << ~k;
         end
         3'd6: begin
            shifted = bus.mem_rsp_data >> {k, 3'b000};
            ben = 4'hf >> k;
         end
         default: shifted = bus.mem_rsp_data;
      endcase
      mask = {{8{ben[3]}}, {8{ben[2]}}, {8{ben[1]}}, {8{ben[0]}}};
      merged = (shifted & mask) | (rt_old_q & ~mask);
   end
   // Reserved select 7 is checked like LW; LB/LBU/LWL/LWR never fault.
   assign misaligned = ((bus.req_load_sel == 3'd2 || bus.req_load_sel == 3'd3) && bus.req_addr[0]) ||
                       ((bus.req_load_sel == 3'd4 || bus.req_load_sel == 3'd7) && bus.req_addr[1:0] != 2'b00);
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      sel_d = sel_q;
      rt_old_d = rt_old_q;
      dest_d = dest_q;
      adel_d = 1'b0;
      wb_data_d = wb_data_q;
      wb_ben_d = wb_ben_q;
      case (state_q)
         IDLE: if (bus.req_valid && !bus.flush) begin
            addr_d = bus.req_addr;
            sel_d = bus.req_load_sel;
            rt_old_d = bus.req_rt_old;
            dest_d = bus.req_dest;
            adel_d = misaligned;
            state_d = misaligned ? IDLE : REQ;
         end
         REQ: if (bus.flush) state_d = bus.mem_rd_ready ? DRAIN : IDLE;
              else if (bus.mem_rd_ready) state_d = WAIT;
         WAIT: if (bus.mem_rsp_valid) begin
            state_d = bus.flush ? IDLE : WB;
            wb_data_d = merged;
            wb_ben_d = ben;
         end else if (bus.flush) state_d = DRAIN;
         WB: if (bus.wb_ready || bus.flush) state_d = IDLE;
         DRAIN: if (bus.mem_rsp_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         addr_q <= '0;
         sel_q <= '0;
         rt_old_q <= '0;
         dest_q <= '0;
         adel_q <= 1'b0;
         wb_data_q <= '0;
         wb_ben_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         sel_q <= sel_d;
         rt_old_q <= rt_old_d;
         dest_q <= dest_d;
         adel_q <= adel_d;
         wb_data_q <= wb_data_d;
         wb_ben_q <= wb_ben_d;
      end
   end
   assign bus.req_ready = state_q == IDLE;
   assign bus.busy = state_q != IDLE;
   assign bus.mem_rd_valid = state_q == REQ;
   assign bus.mem_rd_addr = {addr_q[31:2], 2'b00};
   assign bus.wb_valid = state_q == WB;
   assign bus.wb_dest = dest_q;
   assign bus.wb_data = wb_data_q;
   assign bus.wb_ben = wb_ben_q;
   assign bus.adel = adel_q;
endmodule
